hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Producer side of the EX-stage operand-select interface.
- Keeps a shadow copy of the destination and control info for the ID, EX, MEM and WB slots. Advances that copy every cycle in lockstep with the pipeline registers.
- Generates registered forwardA/forwardB codes for the instruction entering EX.
- Detects load-use hazards and drives the pipeline stall and bubble controls.
- Drives flushes on taken branches resolved in EX.
- Counts stall and flush events.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- valid_ID  input  1  ID slot holds a real instruction.
- RS1_ID  input  5  rs1 of the ID instruction.
- RS2_ID  input  5  rs2 of the ID instruction.
- RD_ID  input  5  rd of the ID instruction.
- uses_rs1_ID  input  1  ID instruction reads rs1.
- uses_rs2_ID  input  1  ID instruction reads rs2.
- RegWrite_ID  input  1  ID instruction writes rd.
- MemRead_ID  input  1  ID instruction is a load.
- branch_taken_EX  input  1  branch in EX is taken this cycle.
- forwardA  output  2  EX operand A select: 00 regfile, 10 ALU_OUT_MEM, 01 ALU_DATA_WB.
- forwardB  output  2  EX operand B select, same encoding as forwardA.
- PCWrite  output  1  PC update enable.
- IF_IDWrite  output  1  IF/ID register load enable.
- bubble_EX  output  1  zero the control fields loaded into ID/EX.
- flush_IF_ID  output  1  squash the IF/ID contents.
- flush_ID_EX  output  1  squash the ID/EX contents.
- stall_cnt  output  CNT_W  load-use stall cycles.
- flush_cnt  output  CNT_W  taken-branch flushes.

Behaviour:
- State:
  - Three registered slots, EX, MEM and WB. Each slot holds {valid, rd, RegWrite, MemRead}.
  - Registered forwardA/forwardB.
  - Two counters, stall_cnt and flush_cnt.
- Reset: synchronous. On reset all slots are invalid, forwardA = forwardB = 00, and both counters are 0.
- A slot "writes r" when valid & RegWrite & rd == r & r != 0. x0 is never forwarded and never stalls.
- load_use (combinational) is true when all of the following hold:
  - valid_ID;
  - the EX slot is valid with MemRead = 1 and RegWrite = 1;
  - (uses_rs1_ID & the EX slot writes RS1_ID) | (uses_rs2_ID & the EX slot writes RS2_ID).
- stall = load_use & ~branch_taken_EX. A branch always wins because the ID instruction is on the wrong path.
- Combinational outputs:
  - PCWrite = IF_IDWrite = ~stall.
  - bubble_EX = stall.
  - flush_IF_ID = flush_ID_EX = branch_taken_EX.
- Slot advance, every rising edge when not in reset:
  - MEM slot <- EX slot.
  - WB slot <- MEM slot.
  - EX slot <- ID info if ~stall & ~branch_taken_EX; otherwise the EX slot becomes invalid (bubble).
- Forward computation: registered, so the value is stable for the whole EX cycle. It is evaluated at the same edge the ID instruction enters EX, against the slots that will be MEM and WB next cycle, i.e. the current EX and MEM slots.
  - forwardA = 10 if uses_rs1_ID & the current EX slot writes RS1_ID.
  - Otherwise forwardA = 01 if uses_rs1_ID & the current MEM slot writes RS1_ID.
  - Otherwise forwardA = 00.
  - forwardB uses the same rules with RS2_ID / uses_rs2_ID.
  - The newer producer (MEM) has priority over WB.
  - When the EX slot is loaded with a bubble, both forward codes become 00.
- A load in the MEM slot never yields forward 10. A load-use pair is always separated by one bubble, so the load is in WB and gets 01.
- Distance-3 producers are not this block's concern. The register file's write-through covers them.
- Counters:
  - stall_cnt increments on every cycle stall = 1.
  - flush_cnt increments on every cycle branch_taken_EX = 1.
  - Both saturate at 2^CNT_W - 1 and do not wrap.
- Reset mid-stall: the outputs return to their reset values on the next edge.

Test Plan:
- ALU chain: add x5 ← …, then add x6,x5,x1 on the next cycle -> forwardA = 10 during the second instruction's EX; forwardB = 00; no stall.
- Distance 2: add x5; nop; sub x7,x2,x5 -> forwardB = 01 in sub's EX. Both x5 producers present -> 10 wins.
- Load-use: lw x8; add x9,x8,x8 -> exactly one cycle with PCWrite = 0, IF_IDWrite = 0, bubble_EX = 1. Then add enters EX with forwardA = forwardB = 01. stall_cnt = 1.
- x0 and unused operands: lw x0 then add x1,x0,x0 -> no stall and forwards 00. lw x3 then lui x3 (uses_rs1 = 0) -> no stall.
- Branch vs stall: lw x4 in EX, dependent instruction in ID, branch_taken_EX = 1 in the same cycle -> stall = 0, flush_IF_ID = flush_ID_EX = 1, the EX slot becomes a bubble, flush_cnt = 1, stall_cnt unchanged.
- Saturation/reset: with CNT_W = 2, four stalls -> stall_cnt = 3. Assert reset for one cycle -> counters 0 and forwards 00 after that edge.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Tracks the EX/MEM/WB destination info and emits registered forward codes plus stall/flush controls.
module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_ID,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic [4:0]       RD_ID,
  input  logic             uses_rs1_ID,
  input  logic             uses_rs2_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic             branch_taken_EX,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             bubble_EX,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  localparam int EX  = 0;
  localparam int MEM = 1;

  slot_t            slot_reg  [3];
  slot_t            slot_next [3];
  logic [1:0]       fwd_a_reg, fwd_b_reg;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic ex_hit_rs1, ex_hit_rs2, load_use, stall, load_ex;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic writes(input slot_t s, input logic [4:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_code(input logic use_rs, input logic [4:0] r,
                                          input slot_t ex_s, input slot_t mem_s);
    if (use_rs && writes(ex_s, r))
      return 2'b10;
    else if (use_rs && writes(mem_s, r))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ex_hit_rs1 = uses_rs1_ID && writes(slot_reg[EX], RS1_ID);
    ex_hit_rs2 = uses_rs2_ID && writes(slot_reg[EX], RS2_ID);
    load_use   = valid_ID && slot_reg[EX].valid && slot_reg[EX].mem_read &&
                 slot_reg[EX].reg_write && (ex_hit_rs1 || ex_hit_rs2);
  end

  // A taken branch squashes the ID instruction, so it overrides any stall.
  assign stall   = load_use && !branch_taken_EX;
  assign load_ex = !stall && !branch_taken_EX;

  assign PCWrite     = !stall;
  assign IF_IDWrite  = !stall;
  assign bubble_EX   = stall;
  assign flush_IF_ID = branch_taken_EX;
  assign flush_ID_EX = branch_taken_EX;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      if (gi == 0) begin : g_ex
        assign slot_next[gi] = load_ex ? '{valid: valid_ID, rd: RD_ID, reg_write: RegWrite_ID,
                                           mem_read: MemRead_ID} : '0;
      end else begin : g_shift
        assign slot_next[gi] = slot_reg[gi-1];
      end

      always_ff @(posedge clk) begin
        if (reset)
          slot_reg[gi] <= '0;
        else
          slot_reg[gi] <= slot_next[gi];
      end
    end
  endgenerate

  // Codes are computed against today's EX/MEM, which become MEM/WB when this instruction is in EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_reg <= 2'b00;
      fwd_b_reg <= 2'b00;
    end else if (load_ex) begin
      fwd_a_reg <= fwd_code(uses_rs1_ID, RS1_ID, slot_reg[EX], slot_reg[MEM]);
      fwd_b_reg <= fwd_code(uses_rs2_ID, RS2_ID, slot_reg[EX], slot_reg[MEM]);
    end else begin
      fwd_a_reg <= 2'b00;
      fwd_b_reg <= 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (branch_taken_EX && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign forwardA  = fwd_a_reg;
  assign forwardB  = fwd_b_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed pipeline scenarios plus randomized traffic
// checked every cycle against an instruction-history model.
module tb_hazard_forward_unit;

  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_ID;
  logic [4:0]    RS1_ID, RS2_ID, RD_ID;
  logic          uses_rs1_ID, uses_rs2_ID, RegWrite_ID, MemRead_ID;
  logic          branch_taken_EX;
  logic [1:0]    forwardA, forwardB;
  logic          PCWrite, IF_IDWrite, bubble_EX, flush_IF_ID, flush_ID_EX;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_forward_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .valid_ID(valid_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .RD_ID(RD_ID), .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .branch_taken_EX(branch_taken_EX),
    .forwardA(forwardA), .forwardB(forwardB), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .bubble_EX(bubble_EX), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model: history of what entered EX, newest first (q[0] is in EX, q[1] in MEM).
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } rec_t;
  rec_t q[$];
  int m_fa, m_fb, m_sc, m_fc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit wr(input rec_t r, input int reg_no);
    return r.v && r.rw && (r.rd == reg_no) && (reg_no != 0);
  endfunction

  function automatic int fcode(input bit use_rs, input int reg_no);
    if (use_rs && wr(q[0], reg_no)) return 2;
    if (use_rs && wr(q[1], reg_no)) return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit hit;
    hit = (uses_rs1_ID && wr(q[0], int'(RS1_ID))) || (uses_rs2_ID && wr(q[0], int'(RS2_ID)));
    return valid_ID && q[0].v && q[0].mr && q[0].rw && hit && !branch_taken_EX;
  endfunction

  task automatic model_update();
    rec_t n;
    bit st, ld;
    if (reset) begin
      q = {};
      n = '{v: 0, rd: 0, rw: 0, mr: 0};
      q.push_front(n);
      q.push_front(n);
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    end else begin
      st = m_stall();
      ld = !st && !branch_taken_EX;
      if (st && m_sc < CMAX) m_sc++;
      if (branch_taken_EX && m_fc < CMAX) m_fc++;
      m_fa = ld ? fcode(uses_rs1_ID, int'(RS1_ID)) : 0;
      m_fb = ld ? fcode(uses_rs2_ID, int'(RS2_ID)) : 0;
      n = '{v: 0, rd: 0, rw: 0, mr: 0};
      if (ld) n = '{v: valid_ID, rd: int'(RD_ID), rw: RegWrite_ID, mr: MemRead_ID};
      q.push_front(n);
      while (q.size() > 3) void'(q.pop_back());
    end
  endtask

  // Single compare process: every negedge, DUT against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("PCWrite", int'(PCWrite), int'(!m_stall()));
      chk("IF_IDWrite", int'(IF_IDWrite), int'(!m_stall()));
      chk("bubble_EX", int'(bubble_EX), int'(m_stall()));
      chk("flush_IF_ID", int'(flush_IF_ID), int'(branch_taken_EX));
      chk("flush_ID_EX", int'(flush_ID_EX), int'(branch_taken_EX));
      chk("forwardA", int'(forwardA), m_fa);
      chk("forwardB", int'(forwardB), m_fb);
      chk("stall_cnt", int'(stall_cnt), m_sc);
      chk("flush_cnt", int'(flush_cnt), m_fc);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                        input bit u1, input bit u2, input bit rw, input bit mr);
    valid_ID = v; RS1_ID = 5'(rs1); RS2_ID = 5'(rs2); RD_ID = 5'(rd);
    uses_rs1_ID = u1; uses_rs2_ID = u2; RegWrite_ID = rw; MemRead_ID = mr;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    branch_taken_EX = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    branch_taken_EX = 1'b0;
    nop();
    tick();
    tick();
    check_en = 1'b1;
    reset = 1'b0;
    chk("rst_forwardA", int'(forwardA), 0);
    chk("rst_forwardB", int'(forwardB), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);

    // ALU chain: add x5; add x6,x5,x1
    set_id(1, 1, 2, 5, 1, 1, 1, 0); tick();
    set_id(1, 5, 1, 6, 1, 1, 1, 0); #1 chk("alu_no_stall", int'(PCWrite), 1); tick();
    chk("alu_fwdA", int'(forwardA), 2);
    chk("alu_fwdB", int'(forwardB), 0);

    // Distance 2: add x5; nop; sub x7,x2,x5
    set_id(1, 1, 2, 5, 1, 1, 1, 0); tick();
    nop(); tick();
    set_id(1, 2, 5, 7, 1, 1, 1, 0); tick();
    chk("dist2_fwdB", int'(forwardB), 1);
    // Both producers present: newer wins
    set_id(1, 1, 2, 5, 1, 1, 1, 0); tick();
    set_id(1, 3, 4, 5, 1, 1, 1, 0); tick();
    set_id(1, 2, 5, 7, 1, 1, 1, 0); tick();
    chk("prio_fwdB", int'(forwardB), 2);

    // Load-use: lw x8; add x9,x8,x8
    do_reset();
    set_id(1, 1, 0, 8, 1, 0, 1, 1); tick();
    set_id(1, 8, 8, 9, 1, 1, 1, 0);
    #1 chk("lu_PCWrite", int'(PCWrite), 0);
    chk("lu_bubble", int'(bubble_EX), 1);
    tick();
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    chk("lu_bubble_fwdA", int'(forwardA), 0);
    #1 chk("lu_resume", int'(PCWrite), 1);
    tick();
    chk("lu_fwdA", int'(forwardA), 1);
    chk("lu_fwdB", int'(forwardB), 1);

    // x0 and unused operands
    set_id(1, 1, 0, 0, 1, 0, 1, 1); tick();
    set_id(1, 0, 0, 1, 1, 1, 1, 0); #1 chk("x0_no_stall", int'(bubble_EX), 0); tick();
    chk("x0_fwdA", int'(forwardA), 0);
    set_id(1, 1, 0, 3, 1, 0, 1, 1); tick();
    set_id(1, 3, 3, 3, 0, 0, 1, 0); #1 chk("lui_no_stall", int'(bubble_EX), 0); tick();

    // Branch beats stall
    do_reset();
    set_id(1, 1, 0, 4, 1, 0, 1, 1); tick();
    set_id(1, 4, 0, 5, 1, 0, 1, 0); branch_taken_EX = 1'b1;
    #1 chk("br_PCWrite", int'(PCWrite), 1);
    chk("br_flush", int'(flush_ID_EX), 1);
    tick();
    branch_taken_EX = 1'b0;
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_stall_cnt", int'(stall_cnt), 0);
    #1 chk("br_ex_bubble", int'(bubble_EX), 0);
    tick();

    // Saturation then reset
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_id(1, 1, 0, 8, 1, 0, 1, 1); tick();
      set_id(1, 8, 0, 9, 1, 0, 1, 0); tick();
    end
    chk("sat_stall_cnt", int'(stall_cnt), CMAX);
    set_id(1, 1, 0, 8, 1, 0, 1, 1); tick();
    set_id(1, 8, 0, 9, 1, 0, 1, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_stall_cnt", int'(stall_cnt), 0);
    chk("rst2_fwdA", int'(forwardA), 0);

    // Randomized traffic on a small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      set_id(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0));
      branch_taken_EX = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
